// File: rtl/coin_change_dispenser.sv
// Greedy 50/10/5/1 coin dispenser with per-denomination stock and shortfall reporting.
// Optional feature macro: COIN_GAP_EN inserts GAP_CYCLES idle cycles between coins.
module coin_change_dispenser #(
    parameter int STOCK_W    = 6,
    parameter int INIT_STOCK = 20,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [6:0]         req_amount,
    output logic               req_ready,
    output logic [6:0]         coin_out,
    output logic               coin_valid,
    output logic               busy,
    output logic               done,
    output logic [6:0]         shortfall,
    input  logic               stock_load,
    input  logic [1:0]         stock_sel,
    input  logic [STOCK_W-1:0] stock_val,
    output logic [3:0]         stock_empty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [6:0]         remaining;
    logic [6:0]         remaining_after;
    logic [STOCK_W-1:0] stock [4];

    logic               pick_found;
    logic [1:0]         pick_sel;
    logic [6:0]         pick_value;
    logic               gap_wait;
    logic               accept;
    logic               fire;
    logic               starve;

    // Largest denomination that fits the remainder and still has stock.
    always_comb begin
        pick_found = 1'b0;
        pick_sel   = 2'd0;
        pick_value = 7'd0;
        if (remaining >= 7'd50 && stock[3] != '0) begin
            pick_found = 1'b1;
            pick_sel   = 2'd3;
            pick_value = 7'd50;
        end else if (remaining >= 7'd10 && stock[2] != '0) begin
            pick_found = 1'b1;
            pick_sel   = 2'd2;
            pick_value = 7'd10;
        end else if (remaining >= 7'd5 && stock[1] != '0) begin
            pick_found = 1'b1;
            pick_sel   = 2'd1;
            pick_value = 7'd5;
        end else if (remaining >= 7'd1 && stock[0] != '0) begin
            pick_found = 1'b1;
            pick_sel   = 2'd0;
            pick_value = 7'd1;
        end
    end

`ifdef COIN_GAP_EN
    logic [3:0] gap_cnt;

    assign gap_wait = (gap_cnt != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= 4'd0;
        end else if (state == S_DISPENSE) begin
            if (gap_wait) begin
                gap_cnt <= gap_cnt - 4'd1;
            end else if (fire && remaining_after != 7'd0) begin
                gap_cnt <= 4'(GAP_CYCLES);
            end
        end else begin
            gap_cnt <= 4'd0;
        end
    end
`else
    // Without the gap feature GAP_CYCLES is inert; this folds to a constant 0.
    assign gap_wait = (GAP_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = (state == S_IDLE);
        busy            = (state != S_IDLE);
        accept          = (state == S_IDLE) && req_valid;
        fire            = (state == S_DISPENSE) && !gap_wait && pick_found;
        starve          = (state == S_DISPENSE) && !gap_wait && !pick_found;
        remaining_after = remaining - pick_value;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (req_amount == 7'd0) ? S_DONE : S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if ((fire && remaining_after == 7'd0) || starve) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE edge raises done, the second returns to IDLE.
                if (done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining   <= 7'd0;
            coin_out    <= 7'd0;
            coin_valid  <= 1'b0;
            done        <= 1'b0;
            shortfall   <= 7'd0;
            stock_empty <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            stock_empty <= {stock[3] == '0, stock[2] == '0, stock[1] == '0, stock[0] == '0};
            coin_out    <= 7'd0;
            coin_valid  <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (stock_load) begin
                        stock[stock_sel] <= stock_val;
                    end
                    if (accept) begin
                        remaining <= req_amount;
                        shortfall <= 7'd0;
                    end
                end
                S_DISPENSE: begin
                    if (fire) begin
                        coin_out        <= pick_value;
                        coin_valid      <= 1'b1;
                        remaining       <= remaining_after;
                        stock[pick_sel] <= stock[pick_sel] - STOCK_W'(1);
                    end else if (starve) begin
                        shortfall <= remaining;
                        remaining <= 7'd0;
                    end
                end
                S_DONE: begin
                    done <= !done;
                end
                default: begin
                    remaining <= 7'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Self-checking bench for coin_change_dispenser: vector table, coin scoreboard, corner sequences.
// Also covers the COIN_GAP_EN build when that macro is defined.
module tb_coin_change_dispenser;

    localparam int STOCK_W    = 6;
    localparam int INIT_STOCK = 20;
`ifdef COIN_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    logic               clk;
    logic               reset;
    logic               req_valid;
    logic [6:0]         req_amount;
    logic               req_ready;
    logic [6:0]         coin_out;
    logic               coin_valid;
    logic               busy;
    logic               done;
    logic [6:0]         shortfall;
    logic               stock_load;
    logic [1:0]         stock_sel;
    logic [STOCK_W-1:0] stock_val;
    logic [3:0]         stock_empty;

    coin_change_dispenser #(
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .coin_out   (coin_out),
        .coin_valid (coin_valid),
        .busy       (busy),
        .done       (done),
        .shortfall  (shortfall),
        .stock_load (stock_load),
        .stock_sel  (stock_sel),
        .stock_val  (stock_val),
        .stock_empty(stock_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int amount;
        int exp_coins;
        int exp_short;
    } vec_t;

    vec_t vecs [6];
    int   exp_q [$];
    int   model_stock [4];
    int   n_checks = 0;
    int   n_errors = 0;
    int   den_val [4] = '{50, 10, 5, 1};
    int   den_sel [4] = '{3, 2, 1, 0};

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Greedy reference: queues the expected coin sequence and debits the model stock.
    task automatic push_model(input int amount);
        int rem = amount;
        bit found = 1'b1;
        while (rem > 0 && found) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (!found && den_val[j] <= rem && model_stock[den_sel[j]] > 0) begin
                    found = 1'b1;
                    rem -= den_val[j];
                    model_stock[den_sel[j]]--;
                    exp_q.push_back(den_val[j]);
                end
            end
        end
    endtask

    function automatic int exp_latency(input int amount, input int n, input int sf);
        int g;
`ifdef COIN_GAP_EN
        g = GAP;
`else
        g = 0;
`endif
        if (amount == 0) return 1;
        if (sf == 0) return 2 + (n - 1) * (g + 1);
        return n * (g + 1) + 2;
    endfunction

    task automatic do_reset();
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_amount = 7'd0;
        stock_load = 1'b0;
        stock_sel  = 2'd0;
        stock_val  = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) model_stock[i] = INIT_STOCK;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_stock(input int sel, input int val);
        @(negedge clk);
        stock_load = 1'b1;
        stock_sel  = 2'(sel);
        stock_val  = STOCK_W'(val);
        model_stock[sel] = val;
        @(posedge clk);
        #1 stock_load = 1'b0;
    endtask

    task automatic applyStimulus(input int amount, input bit hold);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 7'(amount);
        push_model(amount);
        @(posedge clk);
        #1 if (!hold) req_valid = 1'b0;
    endtask

    task automatic check_stocks(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s stock[%0d]", tag, i), int'(dut.stock[i]), model_stock[i]);
        end
    endtask

    // Starts just after the accept edge; cycle index counts edges since the accept.
    task automatic drain_request(input string tag, input int exp_n, input int exp_sf, input int exp_lat);
        int coins = 0;
        int ready_cnt = 0;
        int lat = -1;
        int exp_coin;
        for (int cyc = 0; cyc <= 600 && lat < 0; cyc++) begin
            @(negedge clk);
            if (req_ready) ready_cnt++;
            if (coin_valid) begin
                coins++;
                if (exp_q.size() == 0) begin
                    checkOutput({tag, " unexpected_coin"}, int'(coin_valid), 0);
                end else begin
                    exp_coin = exp_q.pop_front();
                    checkOutput($sformatf("%s coin%0d", tag, coins), int'(coin_out), exp_coin);
                end
            end
            if (done) begin
                lat = cyc;
                checkOutput({tag, " coin_valid_at_done"}, int'(coin_valid), 0);
            end
        end
        if (lat < 0) checkOutput({tag, " done_timeout"}, int'(done), 1);
        checkOutput({tag, " latency"}, lat, exp_lat);
        checkOutput({tag, " coin_count"}, coins, exp_n);
        checkOutput({tag, " shortfall"}, int'(shortfall), exp_sf);
        checkOutput({tag, " ready_while_busy"}, ready_cnt, 0);
        checkOutput({tag, " queue_left"}, exp_q.size(), 0);
        @(negedge clk);
        checkOutput({tag, " done_one_cycle"}, int'(done), 0);
        checkOutput({tag, " ready_after"}, int'(req_ready), 1);
    endtask

    initial begin
        int seen;
        int exp_coin;

        vecs[0] = '{amount: 66,  exp_coins: 4,  exp_short: 0};
        vecs[1] = '{amount: 127, exp_coins: 7,  exp_short: 0};
        vecs[2] = '{amount: 0,   exp_coins: 0,  exp_short: 0};
        vecs[3] = '{amount: 3,   exp_coins: 3,  exp_short: 0};
        vecs[4] = '{amount: 99,  exp_coins: 10, exp_short: 0};
        vecs[5] = '{amount: 55,  exp_coins: 2,  exp_short: 0};

        // Reset values, both during and after reset.
        reset = 1'b0;
        req_valid = 1'b0;
        req_amount = 7'd0;
        stock_load = 1'b0;
        stock_sel = 2'd0;
        stock_val = '0;
        #12;
        checkOutput("rst coin_valid", int'(coin_valid), 0);
        checkOutput("rst req_ready", int'(req_ready), 1);
        do_reset();
        checkOutput("init req_ready", int'(req_ready), 1);
        checkOutput("init busy", int'(busy), 0);
        checkOutput("init coin_valid", int'(coin_valid), 0);
        checkOutput("init done", int'(done), 0);
        checkOutput("init shortfall", int'(shortfall), 0);
        checkOutput("init stock_empty", int'(stock_empty), 0);
        check_stocks("init");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].amount, 1'b0);
            drain_request($sformatf("vec%0d", i), vecs[i].exp_coins, vecs[i].exp_short,
                          exp_latency(vecs[i].amount, vecs[i].exp_coins, vecs[i].exp_short));
        end
        check_stocks("table");

        // Starved denominations; stock1 reload lands on the same edge as the accept.
        load_stock(2, 0);
        load_stock(1, 1);
        @(negedge clk);
        stock_load = 1'b1;
        stock_sel  = 2'd0;
        stock_val  = STOCK_W'(20);
        req_valid  = 1'b1;
        req_amount = 7'd27;
        model_stock[0] = 20;
        push_model(27);
        @(posedge clk);
        #1;
        stock_load = 1'b0;
        req_valid  = 1'b0;
        drain_request("short27", 21, 2, exp_latency(27, 21, 2));
        @(negedge clk);
        checkOutput("short27 stock_empty", int'(stock_empty), 7);
        check_stocks("short27");

        // Zero request also clears the previous shortfall.
        applyStimulus(0, 1'b0);
        drain_request("zero", 0, 0, 1);

        // req_valid held through a request: second accept only after done.
        do_reset();
        applyStimulus(66, 1'b1);
        drain_request("held_a", 4, 0, exp_latency(66, 4, 0));
        push_model(66);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain_request("held_b", 4, 0, exp_latency(66, 4, 0));
        check_stocks("held");

        // Reset mid-payout.
        applyStimulus(127, 1'b0);
        seen = 0;
        for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
            @(negedge clk);
            if (coin_valid) begin
                seen++;
                exp_coin = exp_q.pop_front();
                checkOutput($sformatf("abort coin%0d", seen), int'(coin_out), exp_coin);
            end
        end
        checkOutput("abort coins_before_reset", seen, 2);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort coin_valid_async", int'(coin_valid), 0);
        checkOutput("abort busy_async", int'(busy), 0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) model_stock[i] = INIT_STOCK;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort req_ready", int'(req_ready), 1);
        checkOutput("abort shortfall", int'(shortfall), 0);
        checkOutput("abort done", int'(done), 0);
        check_stocks("abort");

`ifdef COIN_GAP_EN
        applyStimulus(6, 1'b0);
        drain_request("gap6", 2, 0, exp_latency(6, 2, 0));
`endif

        $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
Dispenses a refund amount as physical coins, one coin per cycle: the other end of the vending controller's coin interface.
- The vendor reports a refund value; this block breaks it down greedily into 50/10/5/1 coins.
- Coins are emitted on a coin bus in the same 7-bit value format the vendor accepts on its coin input.
- Per-denomination stock counters are tracked; any amount that cannot be paid is reported as shortfall.

Parameters:
STOCK_W, 6, width of each denomination stock counter
INIT_STOCK, 20, stock count of every denomination after reset (must fit STOCK_W)
GAP_CYCLES, 1, idle cycles between coins when COIN_GAP_EN is defined (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  refund request valid
req_amount  input  7  refund amount, 0..127
req_ready  output  1  high only in IDLE
coin_out  output  7  value of the coin dispensed this cycle (50/10/5/1), else 0
coin_valid  output  1  coin_out holds a dispensed coin
busy  output  1  high in DISPENSE and DONE
done  output  1  one-cycle pulse at end of request
shortfall  output  7  undispensed remainder of the last request
stock_load  input  1  write a stock counter (honoured in IDLE only)
stock_sel  input  2  0=1, 1=5, 2=10, 3=50
stock_val  input  STOCK_W  value written
stock_empty  output  4  bit i high when stock of denomination i is 0 (same encoding as stock_sel)

Behaviour:
- Reset (reset low, async):
  - State IDLE; all stocks = INIT_STOCK; remaining = 0.
  - coin_out = 0, coin_valid = 0, done = 0, busy = 0, shortfall = 0, stock_empty = 0, req_ready = 1.
- States: IDLE, DISPENSE, DONE.
  - req_ready = (state == IDLE).
  - busy = (state != IDLE).
- IDLE:
  - Accept on req_valid && req_ready; latch req_amount into remaining and clear shortfall.
  - If amount == 0, go to DONE. Otherwise go to DISPENSE.
  - stock_load in IDLE writes stock[stock_sel] = stock_val on that edge.
  - stock_load together with an accept: both take effect.
- DISPENSE, each edge:
  - Pick the largest d in {50, 10, 5, 1} with d <= remaining and stock[d] > 0.
  - If found: register coin_out = d, coin_valid = 1; remaining -= d; stock[d] -= 1.
  - If remaining reaches 0 after this coin, go to DONE.
  - If no d qualifies with remaining > 0: coin_valid = 0, shortfall = remaining, go to DONE.
- Latency:
  - Accept at edge k; first coin_valid is visible after edge k+1.
  - Coins follow back-to-back, one per cycle.
  - done is registered high for exactly one cycle, after the edge following the last coin (or the shortfall decision).
  - The next edge returns to IDLE.
- DONE: coin_valid = 0, coin_out = 0. shortfall holds until the next accept.
- req_valid while busy: ignored, no queuing; the requester holds it until req_ready.
- stock_load outside IDLE: ignored. Stock never underflows, because a denomination is selected only when its stock > 0.
- Arithmetic: remaining is 7-bit, unsigned, never negative. Stock counters are STOCK_W-bit, with no wrap on decrement.
- stock_empty: registered, updated every edge from the stock counters.
- Reset asserted mid-operation: dispensing aborts immediately; coin_valid drops asynchronously; stocks return to INIT_STOCK; the partial payout is not reported.

Optional Feature:
COIN_GAP_EN
- Defined: after each coin, insert GAP_CYCLES cycles with coin_valid = 0 before the next coin (solenoid recovery). A counter is held in DISPENSE; done timing shifts accordingly.
- Undefined: no gap counter; coins are strictly back-to-back.

Test Plan:
1. Reset release -> req_ready=1, coin_valid=0, shortfall=0, stock_empty=4'b0000; reading stocks shows 20 each.
2. Request 66 -> coins 50, 10, 5, 1 on four consecutive cycles; done one cycle later; shortfall=0; each stock=19.
3. Request 127 -> coins 50, 50, 10, 10, 5, 1, 1; done pulse; shortfall=0.
4. Load stock10=0 and stock5=1, then request 27 -> one 5 followed by twenty 1s; shortfall=2; stock_empty=4'b0111.
5. Request 0 -> no coin_valid; done pulses on the cycle after the accept edge; shortfall=0. Also: req_valid held high during a 66 request -> only one accept; the second accept occurs after done.
6. Request 127; reset pulsed low after 2 coins -> coin_valid=0 immediately; stocks=20; req_ready=1 after release.
   - With COIN_GAP_EN and GAP_CYCLES=2, request 6 -> coin 5, two idle cycles, then coin 1.
